// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: requester FSM states, beat layout and the
// destination decode used by both the requesters and the output-port mux.
package xbar_pkg;

    localparam int unsigned XBAR_MAX_DEST        = 32;
    localparam int unsigned XBAR_MAX_DEST_W      = $clog2(XBAR_MAX_DEST);
    localparam int unsigned XBAR_BEAT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } req_state_e;

    typedef struct packed {
        logic [XBAR_BEAT_DATA_WIDTH-1:0] data;
        logic                            last;
    } beat_t;

    // Destinations past the last port fold onto the last port.
    function automatic int unsigned dest_clamp(input int unsigned dest,
                                               input int unsigned num_dest);
        return (dest >= num_dest) ? num_dest - 1 : dest;
    endfunction

    function automatic logic [XBAR_MAX_DEST-1:0] dest_to_onehot(input int unsigned dest,
                                                               input int unsigned num_dest);
        logic [XBAR_MAX_DEST-1:0]   oh;
        logic [XBAR_MAX_DEST_W-1:0] idx;
        oh      = '0;
        idx     = XBAR_MAX_DEST_W'(dest_clamp(dest, num_dest));
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Input beat buffer for the stream requester.
// STREAM_REQ_GEN_SKID_EN defined : two-entry skid FIFO, one beat per cycle.
// STREAM_REQ_GEN_SKID_EN undefined: single holding register, fill and drain
//                                   never overlap (one beat per two cycles).
module stream_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic push;
    logic pop;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

`ifdef STREAM_REQ_GEN_SKID_EN
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; push and pop may coincide.
    always_comb begin
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + 2'(push) - 2'(pop);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= in_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    assign in_ready_o  = ~full_q;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;

    // Push only happens when empty, so push and pop are mutually exclusive.
    always_comb begin
        data_d = push ? in_data_i : data_q;
        full_d = full_q;
        if (push)     full_d = 1'b1;
        else if (pop) full_d = 1'b0;
    end

    // Holding register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end
`endif

endmodule

// File: rtl/stream_req_gen.sv
// Per-input-port requester: buffers a packet stream, requests the output
// port named by each packet's first beat and forwards beats under grant.
// Buffer variant is selected by STREAM_REQ_GEN_SKID_EN (see stream_skid_buf).
//
//   state | meaning
//   IDLE  | no request; waiting for a first-of-packet beat
//   REQ   | request raised, no beat of this packet moved yet
//   XFER  | packet in progress, request held until the last beat
//   GAP   | one dead cycle so the arbiters re-evaluate
module stream_req_gen
    import xbar_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_DEST   = 4,
    parameter int unsigned DEST_WIDTH = $clog2(NUM_DEST)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic [DEST_WIDTH-1:0] s_dest_i,
    input  logic                  s_last_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [NUM_DEST-1:0]   request_o,
    input  logic [NUM_DEST-1:0]   grant_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i
);

    localparam int unsigned BUF_WIDTH = DEST_WIDTH + 1 + DATA_WIDTH;

    req_state_e               state_q, state_d;
    logic [DEST_WIDTH-1:0]    dest_q, dest_d;
    logic                     first_q, first_d;

    logic                     buf_ready;
    logic                     push;
    logic                     pop;
    logic                     head_valid;
    logic                     head_ready;
    logic [BUF_WIDTH-1:0]     in_word;
    logic [BUF_WIDTH-1:0]     head_word;
    logic [DEST_WIDTH-1:0]    dest_in;
    logic [DEST_WIDTH-1:0]    head_dest;
    logic                     head_last;
    logic [DATA_WIDTH-1:0]    head_data;
    logic                     active;
    logic                     granted;
    logic                     start_valid;
    logic [DEST_WIDTH-1:0]    start_dest;
    logic [XBAR_MAX_DEST-1:0] onehot_full;
    logic                     unused_onehot;

    // Each buffered beat carries its packet's destination; only first beats
    // contribute one, later beats carry zero and are never decoded.
    assign dest_in = first_q ? s_dest_i : '0;
    assign in_word = {dest_in, s_last_i, s_data_i};

    // Ready is forced low while reset is held so nothing is taken mid-reset.
    assign s_ready_o = buf_ready & ~rst_i;
    assign push      = s_valid_i & s_ready_o;

    stream_skid_buf #(
        .WIDTH (BUF_WIDTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (in_word),
        .in_valid_i  (s_valid_i),
        .in_ready_o  (buf_ready),
        .out_data_o  (head_word),
        .out_valid_o (head_valid),
        .out_ready_i (head_ready)
    );

    assign {head_dest, head_last, head_data} = head_word;

    assign active     = (state_q == REQ) || (state_q == XFER);
    assign granted    = grant_i[dest_q];
    assign m_valid_o  = head_valid & granted & active;
    assign head_ready = m_ready_i & granted & active;
    assign pop        = m_valid_o & m_ready_i;
    assign m_data_o   = head_data;
    assign m_last_o   = head_last;

    // Request depends only on state and dest_q, keeping grant_i out of the path.
    assign onehot_full   = dest_to_onehot(32'(dest_q), NUM_DEST);
    assign unused_onehot = ^onehot_full;
    assign request_o     = active ? onehot_full[NUM_DEST-1:0] : '0;

    // Outside a packet the buffer head (or the beat arriving into an empty
    // buffer) is always a first beat, so its destination starts the next packet.
    assign start_valid = head_valid | (push & first_q);
    assign start_dest  = head_valid ? head_dest : s_dest_i;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        first_d = push ? s_last_i : first_q;
        case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                if (start_valid) begin
                    state_d = REQ;
                    dest_d  = DEST_WIDTH'(dest_clamp(32'(start_dest), NUM_DEST));
                end
            end
            REQ, XFER: begin
                if (pop && head_last) state_d = GAP;
                else if (granted)     state_d = XFER;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dest_q  <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_stream_req_gen.sv
module tb_stream_req_gen;

    localparam int DW  = 32;
    localparam int ND  = 4;
    localparam int DSW = 2;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [DW-1:0]  s_data_i;
    logic [DSW-1:0] s_dest_i;
    logic           s_last_i;
    logic           s_valid_i;
    logic           s_ready_o;
    logic [ND-1:0]  request_o;
    logic [ND-1:0]  grant_i;
    logic [DW-1:0]  m_data_o;
    logic           m_last_o;
    logic           m_valid_o;
    logic           m_ready_i;
    logic           grant_en;

    // Arbiter stand-in: grants whatever is requested while grant_en is high.
    assign grant_i = request_o & {ND{grant_en}};

    stream_req_gen #(
        .DATA_WIDTH (DW),
        .NUM_DEST   (ND),
        .DEST_WIDTH (DSW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .s_data_i  (s_data_i),
        .s_dest_i  (s_dest_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .request_o (request_o),
        .grant_i   (grant_i),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  dest;
        logic        last;
    } beat_s;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  req;
    } exp_s;

    beat_s      in_q[$];
    exp_s       exp_q[$];
    int         in_cyc[$];
    int         out_cyc[$];
    logic [3:0] req_log [int];
    logic       mv_log [int];
    logic       model_first = 1'b1;
    int         model_dest = 0;
    logic       in_fire = 1'b0;
    int         vprob = 100;
    int         rprob = 100;

    // Reference: a packet goes to the port named by its first beat (clamped).
    function automatic logic [3:0] exp_req(input int d);
        int dd;
        dd = (d >= ND) ? ND - 1 : d;
        return 4'(1 << dd);
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    initial begin
        exp_s e;
        forever begin
            @(negedge clk);
            req_log[cyc] = request_o;
            mv_log[cyc]  = m_valid_o;
            in_fire      = 1'b0;
            if (!rst_i) begin
                if (m_valid_o && m_ready_i) begin
                    out_cyc.push_back(cyc);
                    chk("grant_on_beat", 64'(|(grant_i & request_o)), 64'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", 64'(m_data_o), 64'(e.data));
                        chk("last", 64'(m_last_o), 64'(e.last));
                        chk("req_on_beat", 64'(request_o), 64'(e.req));
                    end
                end
                if (s_valid_i && s_ready_o) begin
                    in_fire = 1'b1;
                    in_cyc.push_back(cyc);
                    if (model_first) model_dest = int'(s_dest_i);
                    e.data = s_data_i;
                    e.last = s_last_i;
                    e.req  = exp_req(model_dest);
                    exp_q.push_back(e);
                    model_first = s_last_i;
                end
            end
        end
    end

    // Source driver and downstream ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (in_fire && in_q.size() > 0) void'(in_q.pop_front());
            if (in_q.size() > 0 && (s_valid_i || $urandom_range(99) < vprob)) begin
                s_valid_i = 1'b1;
                s_data_i  = in_q[0].data;
                s_dest_i  = in_q[0].dest;
                s_last_i  = in_q[0].last;
            end else begin
                s_valid_i = 1'b0;
            end
            m_ready_i = ($urandom_range(99) < rprob);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        in_cyc.delete();
        out_cyc.delete();
    endtask

    task automatic push_beat(input logic [31:0] d, input int dest, input logic last);
        beat_s b;
        b.data = d;
        b.dest = 2'(dest);
        b.last = last;
        in_q.push_back(b);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int t;
        t = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && t < budget) begin
            nclk();
            t++;
        end
        if (t >= budget) chk({tag, "_drain_timeout"}, 64'd0, 64'd1);
        repeat (3) nclk();
    endtask

    task automatic wait_in(input int k, input string tag);
        int t;
        t = 0;
        while (in_cyc.size() < k && t < 1000) begin
            nclk();
            t++;
        end
        if (in_cyc.size() < k) chk({tag, "_in_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_out(input int k, input string tag);
        int t;
        t = 0;
        while (out_cyc.size() < k && t < 1000) begin
            nclk();
            t++;
        end
        if (out_cyc.size() < k) chk({tag, "_out_timeout"}, 64'd0, 64'd1);
    endtask

    int n, l, f, total;

    initial begin
        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_dest_i  = '0;
        s_last_i  = 1'b0;
        m_ready_i = 1'b1;
        grant_en  = 1'b1;

        repeat (3) @(posedge clk);
        nclk();
        chk("rst_s_ready", 64'(s_ready_o), 64'd0);
        chk("rst_request", 64'(request_o), 64'd0);
        chk("rst_m_valid", 64'(m_valid_o), 64'd0);
        chk("rst_m_last", 64'(m_last_o), 64'd0);
        chk("rst_m_data", 64'(m_data_o), 64'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        nclk();
        chk("post_rst_s_ready", 64'(s_ready_o), 64'd1);
        chk("post_rst_request", 64'(request_o), 64'd0);

        // Single 3-beat packet to port 2.
        clear_logs();
        for (int i = 0; i < 3; i++) push_beat(32'hA000_0000 + 32'(i), 2, (i == 2));
        wait_drain("t1", 500);
        n = in_cyc[0];
        l = (out_cyc.size() > 0) ? out_cyc[out_cyc.size() - 1] : n;
        chk("t1_beats", 64'(out_cyc.size()), 64'd3);
        chk("t1_idle_req", 64'(req_log[n]), 64'd0);
        chk("t1_first_latency", 64'(out_cyc[0]), 64'(n + 1));
        for (int k = n + 1; k <= l; k++) chk("t1_req_held", 64'(req_log[k]), 64'b0100);
        chk("t1_gap_req", 64'(req_log[l + 1]), 64'd0);
        chk("t1_gap_valid", 64'(mv_log[l + 1]), 64'd0);

        // Grant withheld for 5 cycles after the request.
        clear_logs();
        @(posedge clk);
        #1 grant_en = 1'b0;
        push_beat(32'hB000_0000, 0, 1'b0);
        push_beat(32'hB000_0001, 1, 1'b1);
        wait_in(1, "t2");
        n = in_cyc[0];
        while (cyc < n + 5) nclk();
        @(posedge clk);
        #1 grant_en = 1'b1;
        wait_drain("t2", 500);
        for (int k = n + 1; k <= n + 5; k++) begin
            chk("t2_req_wait", 64'(req_log[k]), 64'b0001);
            chk("t2_valid_wait", 64'(mv_log[k]), 64'd0);
        end
        chk("t2_first_on_grant", 64'(out_cyc[0]), 64'(n + 6));
        chk("t2_beats", 64'(out_cyc.size()), 64'd2);

        // Grant drops for 2 cycles in the middle of a 4-beat packet.
        clear_logs();
        for (int i = 0; i < 4; i++) push_beat(32'hC000_0000 + 32'(i), 3, (i == 3));
        wait_out(1, "t3");
        f = out_cyc[0];
        @(posedge clk);
        #1 grant_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 grant_en = 1'b1;
        wait_drain("t3", 500);
        chk("t3_stall_a", 64'(mv_log[f + 1]), 64'd0);
        chk("t3_stall_b", 64'(mv_log[f + 2]), 64'd0);
        chk("t3_req_held_a", 64'(req_log[f + 1]), 64'b1000);
        chk("t3_req_held_b", 64'(req_log[f + 2]), 64'b1000);
        chk("t3_resume", 64'(out_cyc[1]), 64'(f + 3));
        chk("t3_beats", 64'(out_cyc.size()), 64'd4);

        // Back-to-back: 1 beat to port 1, then 2 beats to port 3 with the
        // second beat carrying a bogus destination.
        clear_logs();
        push_beat(32'hD000_0001, 1, 1'b1);
        push_beat(32'hD000_0002, 3, 1'b0);
        push_beat(32'hD000_0003, 0, 1'b1);
        wait_drain("t4", 500);
        n = in_cyc[0];
        chk("t4_req_a", 64'(req_log[n + 1]), 64'b0010);
        chk("t4_req_gap", 64'(req_log[n + 2]), 64'b0000);
        chk("t4_req_b1", 64'(req_log[n + 3]), 64'b1000);
        chk("t4_req_b2", 64'(req_log[n + 4]), 64'b1000);
        chk("t4_beats", 64'(out_cyc.size()), 64'd3);

        // Streaming rate inside one packet.
        clear_logs();
        for (int i = 0; i < 8; i++) push_beat(32'hE000_0000 + 32'(i), 2, (i == 7));
        wait_drain("t5", 500);
        chk("t5_beats", 64'(out_cyc.size()), 64'd8);
`ifdef STREAM_REQ_GEN_SKID_EN
        chk("t5_span", 64'(out_cyc[7] - out_cyc[0]), 64'd7);
`else
        chk("t5_span", 64'(out_cyc[7] - out_cyc[0]), 64'd14);
`endif

        // Random traffic: 100 packets with random valid, ready and grant.
        clear_logs();
        total = 0;
        for (int p = 0; p < 100; p++) begin
            int len, dst;
            len = $urandom_range(1, 4);
            dst = $urandom_range(0, 3);
            for (int b = 0; b < len; b++)
                push_beat((32'($urandom) & 32'hFFFF_0000) | 32'(p * 8 + b),
                          (b == 0) ? dst : $urandom_range(0, 3), (b == len - 1));
            total += len;
        end
        vprob = 70;
        rprob = 60;
        begin
            int t;
            t = 0;
            while ((in_q.size() != 0 || exp_q.size() != 0) && t < 30000) begin
                @(posedge clk);
                #1 grant_en = ($urandom_range(99) < 80);
                t++;
            end
            if (t >= 30000) chk("t6_timeout", 64'd0, 64'd1);
        end
        grant_en = 1'b1;
        vprob    = 100;
        rprob    = 100;
        repeat (3) nclk();
        chk("t6_beats", 64'(out_cyc.size()), 64'(total));
        chk("t6_leftover", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a packet.
        clear_logs();
        for (int i = 0; i < 3; i++) push_beat(32'hF000_0000 + 32'(i), 2, (i == 2));
        wait_in(1, "t7");
        nclk();
        chk("t7_pre_req", 64'(request_o), 64'b0100);
        #1;
        rst_i = 1'b1;
        in_q.delete();
        exp_q.delete();
        in_fire     = 1'b0;
        model_first = 1'b1;
        s_valid_i   = 1'b0;
        #1;
        chk("t7_rst_s_ready", 64'(s_ready_o), 64'd0);
        chk("t7_rst_request", 64'(request_o), 64'd0);
        chk("t7_rst_m_valid", 64'(m_valid_o), 64'd0);
        chk("t7_rst_m_last", 64'(m_last_o), 64'd0);
        chk("t7_rst_m_data", 64'(m_data_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        nclk();
        clear_logs();
        push_beat(32'hF100_0000, 1, 1'b0);
        push_beat(32'hF100_0001, 3, 1'b1);
        wait_drain("t7", 500);
        n = in_cyc[0];
        chk("t7_new_req", 64'(req_log[n + 1]), 64'b0010);
        chk("t7_beats", 64'(out_cyc.size()), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
